// File: rtl/radix_sort_pkg.sv
// Shared types and helpers for the streaming LSD radix sorter.
package radix_sort_pkg;

    typedef enum logic [2:0] {LOAD, CLEAR, COUNT, PREFIX, SCATTER, OUTPUT} state_e;

    function automatic int num_passes(input int width, input int rbits);
        return (width + rbits - 1) / rbits;
    endfunction

    // Digit 'pass' of a word; bits above the word width come back as zero.
    function automatic logic [31:0] digit_of(input logic [63:0] word, input int pass,
                                             input int rbits);
        logic [63:0] shifted;
        shifted = word >> (pass * rbits);
        return 32'(shifted & ((64'd1 << rbits) - 64'd1));
    endfunction

endpackage

// File: rtl/radix_bucket_ram.sv
// Bucket count array: asynchronous read, one write per cycle; clr writes zero.
module radix_bucket_ram
    import radix_sort_pkg::*;
#(
    parameter int DEPTH_P  = 1024,
    parameter int ADDR_W_P = 10,
    parameter int DATA_W_P = 5
) (
    input  logic                clk_i,
    input  logic [ADDR_W_P-1:0] addr,
    input  logic                we,
    input  logic                clr,
    input  logic [DATA_W_P-1:0] wdata,
    output logic [DATA_W_P-1:0] rdata
);

    logic [DATA_W_P-1:0] mem [DEPTH_P];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[addr] <= clr ? '0 : wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/radix_sort_10b.sv
// Frame-collecting stable LSD radix sorter with ping-pong buffers.
// Stream handshakes: a beat transfers on a clock edge where valid && ready; the
// sender holds data/last stable while valid && !ready, and valid never drops unsent.
module radix_sort_10b
    import radix_sort_pkg::*;
#(
    parameter int WIDTH_P      = 16,
    parameter int RADIX_BITS_P = 10,
    parameter int N_MAX_P      = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [WIDTH_P-1:0] s_tdata,
    input  logic               s_tvalid,
    output logic               s_tready,
    input  logic               s_tlast,
    output logic [WIDTH_P-1:0] m_tdata,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic               m_tlast,
    output logic               busy_o,
    output logic [2:0]         state_o
);

    localparam int PASSES = num_passes(WIDTH_P, RADIX_BITS_P);
    localparam int NB     = 1 << RADIX_BITS_P;
    localparam int CNT_W  = $clog2(N_MAX_P + 1);
    localparam int IDX_W  = $clog2(N_MAX_P);
    localparam int PASS_W = $clog2(PASSES + 1);

    state_e                  state_q;
    logic [WIDTH_P-1:0]      buf_q [2][N_MAX_P];
    logic                    src_sel_q;
    logic [CNT_W-1:0]        n_q;
    logic [IDX_W-1:0]        idx_q;
    logic [RADIX_BITS_P-1:0] bkt_q;
    logic [CNT_W-1:0]        acc_q;
    logic [PASS_W-1:0]       pass_q;

    logic [WIDTH_P-1:0]      src_word;
    logic [RADIX_BITS_P-1:0] digit;
    logic                    last_elem;
    logic [RADIX_BITS_P-1:0] ram_addr;
    logic                    ram_we;
    logic                    ram_clr;
    logic [CNT_W-1:0]        ram_wdata;
    logic [CNT_W-1:0]        ram_rdata;

    assign src_word  = buf_q[src_sel_q][idx_q];
    assign digit     = RADIX_BITS_P'(digit_of(64'(src_word), int'(pass_q), RADIX_BITS_P));
    assign last_elem = (int'(idx_q) == int'(n_q) - 1);
    assign s_tready  = (state_q == LOAD);
    assign busy_o    = (state_q != LOAD);
    assign state_o   = state_q;

    radix_bucket_ram #(
        .DEPTH_P (NB),
        .ADDR_W_P(RADIX_BITS_P),
        .DATA_W_P(CNT_W)
    ) u_bucket (
        .clk_i(clk_i),
        .addr (ram_addr),
        .we   (ram_we),
        .clr  (ram_clr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    // PREFIX writes the running sum before adding the bucket, giving an exclusive scan.
    always_comb begin
        ram_addr  = bkt_q;
        ram_we    = 1'b0;
        ram_clr   = 1'b0;
        ram_wdata = ram_rdata + CNT_W'(1);
        case (state_q)
            CLEAR:   begin ram_we = 1'b1; ram_clr = 1'b1; end
            COUNT:   begin ram_addr = digit; ram_we = 1'b1; end
            PREFIX:  begin ram_we = 1'b1; ram_wdata = acc_q; end
            SCATTER: begin ram_addr = digit; ram_we = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (state_q == LOAD && s_tvalid) begin
            buf_q[0][n_q[IDX_W-1:0]] <= s_tdata;
        end
        if (state_q == SCATTER) begin
            buf_q[~src_sel_q][ram_rdata[IDX_W-1:0]] <= src_word;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= LOAD;
            n_q       <= '0;
            idx_q     <= '0;
            bkt_q     <= '0;
            acc_q     <= '0;
            pass_q    <= '0;
            src_sel_q <= 1'b0;
            m_tvalid  <= 1'b0;
            m_tlast   <= 1'b0;
            m_tdata   <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (s_tvalid) begin
                        n_q <= n_q + CNT_W'(1);
                        if (s_tlast || int'(n_q) == N_MAX_P - 1) begin
                            state_q <= CLEAR;
                            bkt_q   <= '0;
                        end
                    end
                end
                CLEAR: begin
                    bkt_q <= bkt_q + RADIX_BITS_P'(1);
                    if (&bkt_q) begin
                        state_q <= COUNT;
                        idx_q   <= '0;
                    end
                end
                COUNT: begin
                    idx_q <= idx_q + IDX_W'(1);
                    if (last_elem) begin
                        state_q <= PREFIX;
                        acc_q   <= '0;
                    end
                end
                PREFIX: begin
                    acc_q <= acc_q + ram_rdata;
                    bkt_q <= bkt_q + RADIX_BITS_P'(1);
                    if (&bkt_q) begin
                        state_q <= SCATTER;
                        idx_q   <= '0;
                    end
                end
                SCATTER: begin
                    idx_q <= idx_q + IDX_W'(1);
                    if (last_elem) begin
                        idx_q     <= '0;
                        src_sel_q <= ~src_sel_q;
                        pass_q    <= pass_q + PASS_W'(1);
                        state_q   <= (int'(pass_q) + 1 < PASSES) ? CLEAR : OUTPUT;
                    end
                end
                OUTPUT: begin
                    // The first OUTPUT cycle only primes the output register.
                    if (!m_tvalid || m_tready) begin
                        if (m_tvalid && m_tlast) begin
                            state_q   <= LOAD;
                            n_q       <= '0;
                            pass_q    <= '0;
                            src_sel_q <= 1'b0;
                            idx_q     <= '0;
                            m_tvalid  <= 1'b0;
                            m_tlast   <= 1'b0;
                            m_tdata   <= '0;
                        end else begin
                            m_tvalid <= 1'b1;
                            m_tdata  <= src_word;
                            m_tlast  <= last_elem;
                            idx_q    <= idx_q + IDX_W'(1);
                        end
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_radix_sort_10b.sv
// Bench for radix_sort_10b: table vectors, random frames against a sorting model,
// overflow, backpressure, latency and mid-operation reset sequences.
module tb_radix_sort_10b;
    import radix_sort_pkg::*;

    localparam int W      = 16;
    localparam int R      = 10;
    localparam int NMAX   = 16;
    localparam int NB     = 1 << R;
    localparam int PASSES = 2;

    logic         clk = 1'b0;
    logic         reset_i = 1'b1;
    logic [W-1:0] s_tdata = '0;
    logic         s_tvalid = 1'b0;
    logic         s_tready;
    logic         s_tlast = 1'b0;
    logic [W-1:0] m_tdata;
    logic         m_tvalid;
    logic         m_tready = 1'b1;
    logic         m_tlast;
    logic         busy_o;
    logic [2:0]   state_o;

    int errors = 0;
    int checks = 0;
    logic [W:0] exp_q[$];
    logic bp_mode = 1'b0;
    logic hold_ready = 1'b0;

    typedef struct {
        int           n;
        logic [W-1:0] din [NMAX];
        logic [W-1:0] dout[NMAX];
    } vec_t;
    vec_t vecs[4];

    radix_sort_10b dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .s_tdata (s_tdata),
        .s_tvalid(s_tvalid),
        .s_tready(s_tready),
        .s_tlast (s_tlast),
        .m_tdata (m_tdata),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .m_tlast (m_tlast),
        .busy_o  (busy_o),
        .state_o (state_o)
    );

    // ---------------- clock / ready driver ----------------
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_tready = hold_ready ? 1'b0 : (bp_mode ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    // ---------------- helpers / driver tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_beat(input logic [W-1:0] d, input logic l, input int gap);
        int t;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!s_tready && t < 20000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!s_tready) begin
            errors++;
            $display("FAIL beat_accept: s_tready low for %0d cycles, expected high", t);
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] words[$], input int max_gap);
        for (int i = 0; i < words.size(); i++) begin
            drive_beat(words[i], (i == words.size() - 1), $urandom_range(0, max_gap));
        end
    endtask

    // Reference model: the output frame is simply the accepted words in ascending order.
    task automatic push_sorted(input logic [W-1:0] words[$]);
        logic [W-1:0] s[$];
        s = words;
        s.sort();
        for (int i = 0; i < s.size(); i++) begin
            exp_q.push_back({(i == s.size() - 1), s[i]});
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 30000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d words still outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_state(input logic [2:0] st, input string name);
        int t;
        t = 0;
        while (state_o != st && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk(name, 32'(state_o), 32'(st));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_i  = 1'b1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_s_tready"}, 32'(s_tready), 1);
        chk({tag, "_m_tvalid"}, 32'(m_tvalid), 0);
        chk({tag, "_m_tlast"}, 32'(m_tlast), 0);
        chk({tag, "_m_tdata"}, 32'(m_tdata), 0);
        chk({tag, "_busy"}, 32'(busy_o), 0);
    endtask

    // ---------------- scoreboard / output monitor ----------------
    initial begin
        logic         stalled;
        logic         busy_chk;
        logic [W:0]   held;
        logic [W:0]   e;
        stalled  = 1'b0;
        busy_chk = 1'b0;
        held     = '0;
        forever begin
            @(negedge clk);
            if (reset_i) begin
                stalled  = 1'b0;
                busy_chk = 1'b0;
            end else begin
                if (busy_chk) begin
                    chk("busy_fall", 32'({busy_o, m_tvalid}), 0);
                    busy_chk = 1'b0;
                end
                if (stalled) begin
                    chk("stall_hold", 32'({m_tvalid, m_tlast, m_tdata}), 32'({1'b1, held}));
                end
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL out_extra: got %h with no word expected", {m_tlast, m_tdata});
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_word", 32'({m_tlast, m_tdata}), 32'(e));
                        if (e[W]) busy_chk = 1'b1;
                    end
                    stalled = 1'b0;
                end else if (m_tvalid) begin
                    stalled = 1'b1;
                    held    = {m_tlast, m_tdata};
                end else begin
                    stalled = 1'b0;
                end
            end
        end
    end

    // ---------------- main test ----------------
    initial begin
        logic [W-1:0] words[$];
        int k;
        int base;

        vecs[0].n    = 10;
        vecs[0].din  = '{0:16'h1A3, 1:16'h000, 2:16'h3FF, 3:16'h155, 4:16'h02A, 5:16'h200,
                         6:16'h0F0, 7:16'h001, 8:16'h3FE, 9:16'h100, default:16'h0};
        vecs[0].dout = '{0:16'h000, 1:16'h001, 2:16'h02A, 3:16'h0F0, 4:16'h100, 5:16'h155,
                         6:16'h1A3, 7:16'h200, 8:16'h3FE, 9:16'h3FF, default:16'h0};
        vecs[1].n    = 4;
        vecs[1].din  = '{0:16'h8000, 1:16'h03FF, 2:16'h0400, 3:16'h0401, default:16'h0};
        vecs[1].dout = '{0:16'h03FF, 1:16'h0400, 2:16'h0401, 3:16'h8000, default:16'h0};
        vecs[2].n    = 5;
        vecs[2].din  = '{0:16'd5, 1:16'd3, 2:16'd5, 3:16'd3, 4:16'd0, default:16'h0};
        vecs[2].dout = '{0:16'd0, 1:16'd3, 2:16'd3, 3:16'd5, 4:16'd5, default:16'h0};
        vecs[3].n    = 16;
        vecs[3].din  = '{16'hFFFF, 16'hF00F, 16'h7FFF, 16'h0400, 16'h03FF, 16'h8001,
                         16'h8000, 16'h0001, 16'h1234, 16'hFFFE, 16'h0000, 16'h0800,
                         16'h0C00, 16'h0401, 16'hABCD, 16'h4321};
        vecs[3].dout = '{16'h0000, 16'h0001, 16'h03FF, 16'h0400, 16'h0401, 16'h0800,
                         16'h0C00, 16'h1234, 16'h4321, 16'h7FFF, 16'h8000, 16'h8001,
                         16'hABCD, 16'hF00F, 16'hFFFE, 16'hFFFF};

        do_reset();
        check_reset_outputs("reset");
        chk("reset_state", 32'(state_o), 32'(LOAD));

        // Table vectors, sparse input valid, m_tready held high
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < vecs[v].n; i++) begin
                exp_q.push_back({(i == vecs[v].n - 1), vecs[v].dout[i]});
            end
            for (int i = 0; i < vecs[v].n; i++) begin
                drive_beat(vecs[v].din[i], (i == vecs[v].n - 1), $urandom_range(0, 2));
            end
            wait_drain();
        end

        // Single word frame with latency measurement
        exp_q.push_back({1'b1, 16'h00AB});
        drive_beat(16'h00AB, 1'b1, 0);
        @(negedge clk);
        chk("busy_sorting", 32'(busy_o), 1);
        chk("tready_sorting", 32'(s_tready), 0);
        k = 0;
        while (!m_tvalid && k < 20000) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        base = PASSES * (2 * NB + 2 * 1);
        checks++;
        if (k < base || k > base + 2) begin
            errors++;
            $display("FAIL latency: got %0d cycles expected %0d..%0d", k, base, base + 2);
        end
        wait_drain();

        // Overflow: 20 words without tlast; the tail becomes the next frame
        words.delete();
        for (int i = 0; i < 20; i++) words.push_back(W'($urandom));
        push_sorted(words[0:15]);
        push_sorted(words[16:19]);
        for (int i = 0; i < 20; i++) begin
            drive_beat(words[i], (i == 19), $urandom_range(0, 1));
            if (i == 15) begin
                @(negedge clk);
                chk("overflow_tready", 32'(s_tready), 0);
            end
        end
        wait_drain();

        // Random frames under random backpressure
        bp_mode = 1'b1;
        for (int f = 0; f < 3; f++) begin
            words.delete();
            k = $urandom_range(1, NMAX);
            for (int i = 0; i < k; i++) begin
                words.push_back((f == 1) ? W'($urandom_range(0, 7)) : W'($urandom));
            end
            push_sorted(words);
            send_frame(words, 2);
            wait_drain();
        end
        bp_mode = 1'b0;

        // Reset during SCATTER
        words = '{16'd9, 16'd8, 16'd7};
        send_frame(words, 0);
        wait_state(3'(SCATTER), "reach_scatter");
        do_reset();
        check_reset_outputs("rst_scatter");

        // Reset during OUTPUT while stalled
        hold_ready = 1'b1;
        send_frame(words, 0);
        k = 0;
        while (!m_tvalid && k < 20000) begin
            @(negedge clk);
            k++;
        end
        chk("stall_valid", 32'(m_tvalid), 1);
        repeat (4) @(negedge clk);
        do_reset();
        hold_ready = 1'b0;
        check_reset_outputs("rst_output");

        words = '{16'd2, 16'd1};
        exp_q.push_back({1'b0, 16'd1});
        exp_q.push_back({1'b1, 16'd2});
        send_frame(words, 1);
        wait_drain();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
